// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M divide/remainder unit.
//   div_op_e    - operation encoding, equal to funct3[1:0]
//   div_state_e - div_unit control states
//   DIV_ITERS   - quotient bits produced by the restoring loop
//   INT_MIN     - most negative 32-bit value (signed overflow operand)
//   ALL_ONES    - divide-by-zero quotient / -1 divisor pattern
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  // Signed ops are DIV and REM; both have bit 0 clear.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem_i     - partial remainder (always < divisor_i on entry)
//   quo_i     - remaining dividend bits in the MSBs, quotient bits in the LSBs
//   divisor_i - divisor magnitude
//   rem_o     - next partial remainder
//   quo_o     - quo_i shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    // rem_i < divisor keeps shifted < 2*divisor, so a negative difference
    // always lands in [-2^XLEN, -1] and its top bit is a clean borrow flag.
    ge      = ~diff[XLEN];
    rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per
// cycle, special cases resolved in the accept cycle.
//   clk, rst_n     - clock, synchronous active-low reset
//   start, flush   - request (sampled in IDLE), pipeline kill
//   op             - funct3[1:0]
//   src_a, src_b   - dividend, divisor
//   rd_in          - destination register index
//   busy           - unit not idle (decode stall)
//   done           - one-cycle result-valid strobe (register-file WE)
//   result, rd_out - registered result and destination index
//
// state | meaning
// IDLE  | waiting for start; special cases resolved here
// CALC  | one restoring iteration per cycle, 32 cycles
// FIX   | apply result sign, select quotient or remainder
// DONE  | result valid, done strobe
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic            sgn, a_neg, b_neg;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    count_d   = count_q;

    sgn   = is_signed_op(op);
    a_neg = sgn & src_a[XLEN-1];
    b_neg = sgn & src_b[XLEN-1];

    if (flush) begin
      // Kill in flight; result keeps whatever was last written back.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d      = div_op_e'(op);
            rd_d      = rd_in;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            quo_d     = a_neg ? -src_a : src_a;
            dvsr_d    = b_neg ? -src_b : src_b;
            rem_d     = '0;
            count_d   = '0;
            if (src_b == '0) begin
              result_d = op[1] ? src_a : ALL_ONES;
              state_d  = DONE;
            end else if (sgn && src_a == INT_MIN && src_b == ALL_ONES) begin
              result_d = op[1] ? '0 : INT_MIN;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 1'b1;
          if (count_q == CW'(DIV_ITERS - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          case (op_q)
            DIV:     result_d = neg_quo_q ? -quo_q : quo_q;
            REM:     result_d = neg_rem_q ? -rem_q : rem_q;
            DIVU:    result_d = quo_q;
            default: result_d = rem_q;
          endcase
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      count_q   <= count_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus hand-written sequences for
// back-to-back issue, flush and mid-operation reset of div_unit.
module tb_div_unit;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request during the cycle that follows the next falling edge
  // (that cycle is "cycle 0" of the operation).
  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    rd_in = r;
  endtask

  int          dcyc, bcnt, dcnt;
  logic [31:0] res;
  logic [4:0]  rdo;

  initial begin
    vecs[0]  = '{DIV,  32'd20,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, 34};
    vecs[1]  = '{REM,  32'hFFFF_FFEC,  32'd3,         5'd6,  32'hFFFF_FFFE, 34};
    vecs[2]  = '{REMU, 32'hFFFF_FFFF,  32'd16,        5'd7,  32'h0000_000F, 34};
    vecs[3]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,         5'd8,  32'hFFFF_FFFF, 34};
    vecs[4]  = '{DIV,  32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[5]  = '{REMU, 32'd7,          32'd0,         5'd10, 32'd7,         1};
    vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
    vecs[8]  = '{DIVU, 32'd100,        32'd7,         5'd13, 32'd14,        34};
    vecs[9]  = '{REMU, 32'd100,        32'd7,         5'd14, 32'd2,         34};
    vecs[10] = '{DIV,  32'hFFFF_FFF9,  32'd2,         5'd15, 32'hFFFF_FFFD, 34};
    vecs[11] = '{REM,  32'hFFFF_FFF9,  32'd2,         5'd16, 32'hFFFF_FFFF, 34};
    vecs[12] = '{REM,  32'd7,          32'hFFFF_FFFE, 5'd17, 32'd1,         34};
    vecs[13] = '{DIV,  32'h8000_0000,  32'd2,         5'd18, 32'hC000_0000, 34};
    vecs[14] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'd0,         34};
    vecs[15] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 34};

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   32'(busy),   32'd0);
    check("reset done",   32'(done),   32'd0);
    check("reset result", result,      32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      dcyc = 0;
      bcnt = 0;
      res  = '0;
      rdo  = '0;
      for (int c = 1; c <= 40 && dcyc == 0; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (busy) bcnt++;
        if (done) begin
          dcyc = c;
          res  = result;
          rdo  = rd_out;
        end
      end
      check($sformatf("vec%0d done cycle", i), 32'(dcyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].cyc));
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d rd_out", i), 32'(rdo), 32'(vecs[i].rd));
    end

    // Starts while busy (cycle 5 and the DONE cycle 34) are dropped; the
    // first IDLE cycle 35 accepts a new request.
    launch(DIV, 32'd20, 32'hFFFF_FFFD, 5'd5);
    dcnt = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcnt++;
      if (c == 34) begin
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first result", result, 32'hFFFF_FFFA);
        check("b2b first rd_out", 32'(rd_out), 32'd5);
      end
      if (c == 35) check("b2b idle after done", 32'(busy), 32'd0);
      if (c == 69) begin
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second result", result, 32'd3);
        check("b2b second rd_out", 32'(rd_out), 32'd9);
      end
      if (c == 5 || c == 34 || c == 35) begin
        start = 1'b1;
        op    = DIVU;
        src_a = 32'd9;
        src_b = 32'd3;
        rd_in = 5'd9;
      end
    end
    check("b2b done count", 32'(dcnt), 32'd2);

    // Flush mid-CALC, restart right after, then flush+start in one IDLE cycle.
    launch(DIV, 32'd100, 32'd7, 5'd3);
    dcnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (done) dcnt++;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        check("flush busy", 32'(busy), 32'd0);
        check("flush result kept", result, 32'd3);
        start = 1'b1;
        op    = DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        rd_in = 5'd12;
      end
      if (c == 45) begin
        check("post-flush done", 32'(done), 32'd1);
        check("post-flush result", result, 32'd14);
        check("post-flush rd_out", 32'(rd_out), 32'd12);
      end
      if (c == 47) begin
        start = 1'b1;
        flush = 1'b1;
        op    = DIVU;
        src_a = 32'd50;
        src_b = 32'd0;
        rd_in = 5'd20;
      end
      if (c == 48) check("flush+start busy", 32'(busy), 32'd0);
    end
    check("flush done count", 32'(dcnt), 32'd1);

    // Reset low for one cycle mid-operation.
    launch(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7);
    dcnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcnt++;
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin
        rst_n = 1'b1;
        check("mid-reset busy",   32'(busy),   32'd0);
        check("mid-reset done",   32'(done),   32'd0);
        check("mid-reset result", result,      32'd0);
        check("mid-reset rd_out", 32'(rd_out), 32'd0);
      end
    end
    check("mid-reset done count", 32'(dcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M integer divide/remainder unit in the execute stage. It consumes the two source operands read from the register file and the destination register index. It returns a 32-bit result with a one-cycle `done` strobe that drives the register-file write port (`WD3`, `AD3`, `WE3`) at writeback. It implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm: one quotient bit per cycle, with single-cycle resolution of architectural special cases.

## Interface

**Parameters**
- `XLEN`, default 32: operand/result width. Only 32 is supported; the counter width is log2(XLEN).

**Ports**
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 2: funct3[1:0]. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `src_a` in 32: dividend (RD1).
- `src_b` in 32: divisor (RD2).
- `rd_in` in 5: destination register index.
- `flush` in 1: pipeline kill. Aborts the operation in flight.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle strobe while the result is valid. Feeds `WE3`.
- `result` out 32: quotient or remainder. Feeds `WD3`.
- `rd_out` out 5: registered copy of `rd_in`. Feeds `AD3`.

## Operation

**States:** IDLE, CALC, FIX, DONE.

**IDLE**
- On `start` (and no `flush`), latch `op` and `rd_in`.
- Record `neg_q = sign(a) ^ sign(b)` and `neg_r = sign(a)`, signed ops only.
- Latch |a| and |b| as unsigned magnitudes. Unsigned ops use the raw values.
- Clear the remainder accumulator; set `count` = 0.

**Special cases, detected in IDLE** (skip CALC/FIX; `result` is loaded directly and the next state is DONE):
- Divisor = 0:
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → `src_a` unchanged.
- DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF:
  - DIV → 0x80000000.
  - REM → 0.

**CALC** (each edge performs one iteration)
- Shift {rem, quo} left by 1, bringing in the next dividend MSB.
- If rem ≥ |b|: subtract |b| and set the quotient LSB to 1.
- Compare on 33 bits; no overflow is permitted.
- `count` increments; when `count` = 31, the next state is FIX.

**FIX**
- DIV: `result` = `neg_q` ? −quo : quo.
- REM: `result` = `neg_r` ? −rem : rem.
- Unsigned ops: raw quo or rem.
- Next state is DONE.

**DONE**
- `done` = 1 and `result`/`rd_out` are stable.
- Next state is IDLE unconditionally; no backpressure.

**Boundary rules**
- `start` while `busy` (including the DONE cycle) is ignored. It is not queued.
- `flush` in any non-IDLE state forces IDLE on the next edge. No `done` is produced, and `result` retains its last value.
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- `rst_n` low takes priority over everything, mid-operation included.

**Reset values**
- State IDLE.
- `busy` = 0, `done` = 0.
- `result` = 0, `rd_out` = 0.
- `count` = 0 and all internal accumulators = 0.

## Timing

Take the `start` cycle as cycle 0.
- Normal path:
  - `busy` is high in cycles 1–34.
  - CALC covers cycles 1–32, FIX is cycle 33, DONE is cycle 34.
  - `done` is high in cycle 34 only.
- Special case:
  - DONE is cycle 1, so `busy` and `done` are high in cycle 1.
- Back-to-back: the earliest next accepted `start` is the first IDLE cycle (cycle 35, or cycle 2 for a special case).
- `result`, `rd_out` and `done` are all registered outputs; there is no combinational path from inputs.
- The hazard unit must stall decode while `busy` is high. The writeback mux selects `result` when `done` is high.

## Structure

- Shared package `div_pkg` holds:
  - `div_op_e` (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11).
  - `div_state_e` (IDLE, CALC, FIX, DONE).
  - Constants `DIV_ITERS` = 32, `INT_MIN` = 32'h8000_0000, `ALL_ONES` = 32'hFFFF_FFFF.
- Sub-module `div_step`: purely combinational single iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is instantiated once and registered in `div_unit`.

## Test plan

- DIV 20 / −3 (0xFFFFFFFD), rd=5 → `result` 0xFFFFFFFA, `rd_out` 5, `done` exactly in cycle 34, `busy` cycles 1–34.
- REM −20 / 3 → 0xFFFFFFFE. REMU 0xFFFFFFFF / 16 → 0x0000000F. DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- DIV 5 / 0 → 0xFFFFFFFF. REMU 7 / 0 → 7. DIV 0x80000000 / −1 → 0x80000000. REM of the same operands → 0. All of these assert `done` in cycle 1.
- Re-assert `start` with different operands in cycles 5 and 34 → ignored; the first result is unchanged. A new `start` in cycle 35 is accepted, with `done` in cycle 69.
- `flush` in cycle 10 → state IDLE and `busy` 0 in cycle 11, no `done` ever. A `start` in cycle 11 completes normally with `done` in cycle 45.
- `rst_n` low in cycle 20 for one cycle → cycle 21 shows `busy` 0, `done` 0, `result` 0, `rd_out` 0, with no late `done`.
